// File: rtl/cmd_pkg.sv
// Shared constants for the USB command path: frame markers, error codes,
// command IDs and the parser state encoding.
package cmd_pkg;

   localparam logic [7:0] SOF1 = 8'hAA;
   localparam logic [7:0] SOF2 = 8'h55;

   localparam logic [1:0] ERR_OVERRUN  = 2'b00;
   localparam logic [1:0] ERR_CHECKSUM = 2'b01;
   localparam logic [1:0] ERR_LENGTH   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   localparam logic [7:0] CMD_HEARTBEAT = 8'hFF;
   localparam logic [7:0] CMD_PWM       = 8'hFE;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SOF2,
      ST_CMD,
      ST_LEN_H,
      ST_LEN_L,
      ST_PAYLOAD,
      ST_CHECK,
      ST_EMIT,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/frame_payload_buf.sv
// Simple dual-port payload buffer: synchronous write, registered read that
// only updates on rd_en so the read port doubles as the payload output register.
module frame_payload_buf #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   // NOTE: the storage array is deliberately not reset; every byte is written before it is read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/frame_parser.sv
// USB CDC command frame parser: AA 55 CMD LEN_H LEN_L PAYLOAD CHK.
// Verified frames are released as cmd_start plus a ready/valid payload stream.
module frame_parser
   import cmd_pkg::*;
#(
   parameter int MAX_PAYLOAD  = 64,
   parameter int TIMEOUT_CLKS = 500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  usb_data_in,
   input  logic        usb_data_valid_in,
   output logic        cmd_start,
   output logic [7:0]  cmd_type,
   output logic [15:0] cmd_length,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   input  logic        payload_ready,
   output logic        cmd_done,
   output logic        err_valid,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [15:0]   MAX_LEN = 16'(MAX_PAYLOAD);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

   state_t        state;
   logic [7:0]    chk;
   logic [7:0]    cur_cmd;
   logic [7:0]    len_h;
   logic [15:0]   cur_len;
   logic [15:0]   wr_idx;
   logic [15:0]   rd_idx;
   logic [TW-1:0] idle_cnt;

   logic [15:0]   rx_len;
   logic          xfer;
   logic          timed;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] rd_addr;

   assign rx_len  = {len_h, usb_data_in};
   assign xfer    = payload_valid && payload_ready;
   assign timed   = state inside {ST_SOF2, ST_CMD, ST_LEN_H, ST_LEN_L, ST_PAYLOAD, ST_CHECK};
   assign wr_en   = (state == ST_PAYLOAD) && usb_data_valid_in;
   // Read one byte ahead: address 0 in EMIT, then the next byte on each transfer.
   assign rd_en   = (state == ST_EMIT) || ((state == ST_DRAIN) && xfer);
   assign rd_addr = (state == ST_EMIT) ? '0 : AW'(rd_idx + 16'd1);
   assign busy    = (state != ST_IDLE);

   frame_payload_buf #(
      .DEPTH (MAX_PAYLOAD),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_idx[AW-1:0]),
      .wr_data (usb_data_in),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (payload_data)
   );

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         chk           <= '0;
         cur_cmd       <= '0;
         len_h         <= '0;
         cur_len       <= '0;
         wr_idx        <= '0;
         rd_idx        <= '0;
         idle_cnt      <= '0;
         cmd_start     <= 1'b0;
         cmd_type      <= '0;
         cmd_length    <= '0;
         payload_valid <= 1'b0;
         cmd_done      <= 1'b0;
         err_valid     <= 1'b0;
         err_code      <= '0;
      end else begin
         cmd_start <= 1'b0;
         cmd_done  <= 1'b0;
         err_valid <= 1'b0;

         // A byte in the expiry cycle clears the counter and is processed below.
         if (timed && !usb_data_valid_in) begin
            if (idle_cnt == TO_LAST) begin
               err_valid <= 1'b1;
               err_code  <= ERR_TIMEOUT;
               state     <= ST_IDLE;
               idle_cnt  <= '0;
            end else begin
               idle_cnt <= idle_cnt + TW'(1);
            end
         end else begin
            idle_cnt <= '0;
         end

         case (state)
            ST_IDLE: begin
               if (usb_data_valid_in && usb_data_in == SOF1) state <= ST_SOF2;
            end
            ST_SOF2: begin
               if (usb_data_valid_in) begin
                  if (usb_data_in == SOF2)      state <= ST_CMD;
                  else if (usb_data_in != SOF1) state <= ST_IDLE;
               end
            end
            ST_CMD: begin
               if (usb_data_valid_in) begin
                  cur_cmd <= usb_data_in;
                  chk     <= usb_data_in;
                  state   <= ST_LEN_H;
               end
            end
            ST_LEN_H: begin
               if (usb_data_valid_in) begin
                  len_h <= usb_data_in;
                  chk   <= chk + usb_data_in;
                  state <= ST_LEN_L;
               end
            end
            ST_LEN_L: begin
               if (usb_data_valid_in) begin
                  chk     <= chk + usb_data_in;
                  cur_len <= rx_len;
                  wr_idx  <= '0;
                  if (rx_len > MAX_LEN) begin
                     err_valid <= 1'b1;
                     err_code  <= ERR_LENGTH;
                     state     <= ST_IDLE;
                  end else if (rx_len == 16'd0) begin
                     state <= ST_CHECK;
                  end else begin
                     state <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (usb_data_valid_in) begin
                  chk    <= chk + usb_data_in;
                  wr_idx <= wr_idx + 16'd1;
                  if (wr_idx + 16'd1 == cur_len) state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (usb_data_valid_in) begin
                  if (usb_data_in == chk) begin
                     cmd_start  <= 1'b1;
                     cmd_type   <= cur_cmd;
                     cmd_length <= cur_len;
                     rd_idx     <= '0;
                     state      <= ST_EMIT;
                  end else begin
                     err_valid <= 1'b1;
                     err_code  <= ERR_CHECKSUM;
                     state     <= ST_IDLE;
                  end
               end
            end
            ST_EMIT: begin
               if (cmd_length == 16'd0) begin
                  cmd_done <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  payload_valid <= 1'b1;
                  state         <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (xfer) begin
                  if (rd_idx == cmd_length - 16'd1) begin
                     payload_valid <= 1'b0;
                     cmd_done      <= 1'b1;
                     state         <= ST_IDLE;
                  end else begin
                     rd_idx <= rd_idx + 16'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Handlers own the link while a command is out; stray bytes are dropped.
         if ((state == ST_EMIT || state == ST_DRAIN) && usb_data_valid_in) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
         end
      end
   end

endmodule

// File: tb/tb_frame_parser.sv
// Directed bench for frame_parser: good, corrupt, oversize, resync, timeout,
// backpressure, overrun and reset-during-drain frames.
module tb_frame_parser;
   import cmd_pkg::*;

   localparam int TB_TIMEOUT = 40;
   localparam logic [7:0] PWM_PL [5] = '{8'h01, 8'hEA, 8'h60, 8'h75, 8'h30};

   logic        clk;
   logic        rst_n;
   logic [7:0]  usb_data_in;
   logic        usb_data_valid_in;
   logic        cmd_start;
   logic [7:0]  cmd_type;
   logic [15:0] cmd_length;
   logic [7:0]  payload_data;
   logic        payload_valid;
   logic        payload_ready;
   logic        cmd_done;
   logic        err_valid;
   logic [1:0]  err_code;
   logic        busy;

   int errors = 0;
   int checks = 0;

   frame_parser #(
      .MAX_PAYLOAD  (64),
      .TIMEOUT_CLKS (TB_TIMEOUT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .usb_data_in       (usb_data_in),
      .usb_data_valid_in (usb_data_valid_in),
      .cmd_start         (cmd_start),
      .cmd_type          (cmd_type),
      .cmd_length        (cmd_length),
      .payload_data      (payload_data),
      .payload_valid     (payload_valid),
      .payload_ready     (payload_ready),
      .cmd_done          (cmd_done),
      .err_valid         (err_valid),
      .err_code          (err_code),
      .busy              (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event monitor, sampled mid-cycle away from the active edge.
   int          cyc = 0, n_start = 0, n_done = 0, n_err = 0, n_pv = 0;
   int          start_cyc, done_cyc, err_cyc, byte_cyc;
   logic [7:0]  last_type;
   logic [15:0] last_len;
   logic [1:0]  last_err;
   logic        pv_at_done;
   logic [7:0]  rx_q [$];
   int          xfer_q [$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (usb_data_valid_in) byte_cyc = cyc;
      if (cmd_start) begin
         n_start++; start_cyc = cyc; last_type = cmd_type; last_len = cmd_length;
      end
      if (cmd_done) begin
         n_done++; done_cyc = cyc; pv_at_done = payload_valid;
      end
      if (err_valid) begin
         n_err++; err_cyc = cyc; last_err = err_code;
      end
      if (payload_valid) n_pv++;
      if (payload_valid && payload_ready) begin
         rx_q.push_back(payload_data);
         xfer_q.push_back(cyc);
      end
   end

   logic [7:0] frm [$];

   task automatic send_byte(input logic [7:0] b);
      usb_data_in       = b;
      usb_data_valid_in = 1'b1;
      @(posedge clk); #1;
      usb_data_valid_in = 1'b0;
   endtask

   task automatic send_frm();
      foreach (frm[i]) send_byte(frm[i]);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin @(posedge clk); #1; n++; end
      checks++;
      if (busy) begin errors++; $display("FAIL %s: busy still %b after 200 cycles, required 0", name, busy); end
      idle_cycles(3);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; usb_data_in = '0; usb_data_valid_in = 1'b0; payload_ready = 1'b0;
      idle_cycles(3);
      checks++;
      if ({cmd_start, cmd_done, payload_valid, err_valid, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 00000", {cmd_start, cmd_done, payload_valid, err_valid, busy});
      end
      checks++;
      if ({cmd_type, cmd_length, payload_data, err_code} !== 34'b0) begin
         errors++; $display("FAIL reset_data: type=%h len=%h data=%h code=%b required all 0", cmd_type, cmd_length, payload_data, err_code);
      end
      rst_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_heartbeat();
      int s0 = n_start, d0 = n_done, e0 = n_err, p0 = n_pv;
      frm = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
      send_frm();
      wait_idle("hb_idle");
      checks++;
      if (n_start - s0 !== 1 || last_type !== CMD_HEARTBEAT || last_len !== 16'd0) begin
         errors++; $display("FAIL hb_start: starts=%0d type=%h len=%h required 1/ff/0000", n_start - s0, last_type, last_len);
      end
      checks++;
      if (n_done - d0 !== 1 || done_cyc !== start_cyc + 1) begin
         errors++; $display("FAIL hb_done: dones=%0d at +%0d required 1 at +1", n_done - d0, done_cyc - start_cyc);
      end
      checks++;
      if (n_pv - p0 !== 0 || n_err - e0 !== 0) begin
         errors++; $display("FAIL hb_quiet: pv cycles=%0d errs=%0d required 0/0", n_pv - p0, n_err - e0);
      end
   endtask

   task automatic test_pwm();
      int s0 = n_start, d0 = n_done, e0 = n_err, q0 = rx_q.size();
      payload_ready = 1'b1;
      frm = '{8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h01, 8'hEA, 8'h60, 8'h75, 8'h30, 8'hF3};
      send_frm();
      wait_idle("pwm_idle");
      checks++;
      if (n_start - s0 !== 1 || last_type !== CMD_PWM || last_len !== 16'd5) begin
         errors++; $display("FAIL pwm_start: starts=%0d type=%h len=%h required 1/fe/0005", n_start - s0, last_type, last_len);
      end
      checks++;
      if (rx_q.size() - q0 !== 5) begin
         errors++; $display("FAIL pwm_count: got %0d bytes required 5", rx_q.size() - q0);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[q0+i] !== PWM_PL[i] || xfer_q[q0+i] !== start_cyc + 1 + i) begin
               errors++; $display("FAIL pwm_byte%0d: got %h at +%0d required %h at +%0d", i, rx_q[q0+i], xfer_q[q0+i] - start_cyc, PWM_PL[i], i + 1);
            end
         end
      end
      checks++;
      if (n_done - d0 !== 1 || done_cyc !== start_cyc + 6 || pv_at_done !== 1'b0 || n_err - e0 !== 0) begin
         errors++; $display("FAIL pwm_done: dones=%0d at +%0d pv=%b errs=%0d required 1 at +6 pv=0 errs=0", n_done - d0, done_cyc - start_cyc, pv_at_done, n_err - e0);
      end
   endtask

   task automatic test_bad_checksum();
      int s0 = n_start, e0 = n_err;
      frm = '{8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h01, 8'hEA, 8'h60, 8'h75, 8'h30, 8'hF4};
      send_frm();
      wait_idle("chk_idle");
      checks++;
      if (n_err - e0 !== 1 || last_err !== ERR_CHECKSUM || n_start - s0 !== 0) begin
         errors++; $display("FAIL chk_err: errs=%0d code=%b starts=%0d required 1/01/0", n_err - e0, last_err, n_start - s0);
      end
      frm = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
      send_frm();
      wait_idle("chk_recover_idle");
      checks++;
      if (n_start - s0 !== 1 || last_type !== CMD_HEARTBEAT) begin
         errors++; $display("FAIL chk_recover: starts=%0d type=%h required 1/ff", n_start - s0, last_type);
      end
   endtask

   task automatic test_length();
      int s0 = n_start, e0 = n_err, lcyc;
      frm = '{8'hAA, 8'h55, 8'hFE, 8'h00, 8'h41};
      send_frm();
      lcyc = byte_cyc;
      for (int i = 1; i <= 10; i++) send_byte(8'(i));
      wait_idle("len_idle");
      checks++;
      if (n_err - e0 !== 1 || last_err !== ERR_LENGTH || err_cyc !== lcyc + 1 || n_start - s0 !== 0) begin
         errors++; $display("FAIL len_err: errs=%0d code=%b at +%0d starts=%0d required 1/10 at +1/0", n_err - e0, last_err, err_cyc - lcyc, n_start - s0);
      end
      frm = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
      send_frm();
      wait_idle("len_recover_idle");
      checks++;
      if (n_start - s0 !== 1 || n_err - e0 !== 1) begin
         errors++; $display("FAIL len_recover: starts=%0d errs=%0d required 1/1", n_start - s0, n_err - e0);
      end
   endtask

   task automatic test_resync();
      int s0 = n_start, e0 = n_err;
      frm = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
      send_frm();
      wait_idle("resync_idle");
      checks++;
      if (n_start - s0 !== 1 || last_type !== CMD_HEARTBEAT || n_err - e0 !== 0) begin
         errors++; $display("FAIL resync: starts=%0d type=%h errs=%0d required 1/ff/0", n_start - s0, last_type, n_err - e0);
      end
   endtask

   task automatic test_timeout();
      int s0 = n_start, e0 = n_err, tcyc;
      frm = '{8'hAA, 8'h55, 8'hFE};
      send_frm();
      tcyc = byte_cyc;
      idle_cycles(TB_TIMEOUT + 10);
      checks++;
      if (n_err - e0 !== 1 || last_err !== ERR_TIMEOUT || err_cyc !== tcyc + TB_TIMEOUT + 1 || busy !== 1'b0) begin
         errors++; $display("FAIL to_err: errs=%0d code=%b at +%0d busy=%b required 1/11 at +%0d busy=0", n_err - e0, last_err, err_cyc - tcyc, busy, TB_TIMEOUT + 1);
      end
      // A byte landing exactly on the expiry cycle must win over the timeout.
      send_byte(8'hAA); send_byte(8'h55);
      idle_cycles(TB_TIMEOUT - 1);
      frm = '{8'hFE, 8'h00, 8'h00, 8'hFE};
      send_frm();
      wait_idle("to_edge_idle");
      checks++;
      if (n_start - s0 !== 1 || last_type !== CMD_PWM || n_err - e0 !== 1) begin
         errors++; $display("FAIL to_edge: starts=%0d type=%h errs=%0d required 1/fe/1", n_start - s0, last_type, n_err - e0);
      end
   endtask

   task automatic test_backpressure();
      int d0 = n_done, q0 = rx_q.size(), n = 0;
      payload_ready = 1'b1;
      frm = '{8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h01, 8'hEA, 8'h60, 8'h75, 8'h30, 8'hF3};
      send_frm();
      while (rx_q.size() - q0 < 1 && n < 20) begin @(posedge clk); #1; n++; end
      payload_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (payload_valid !== 1'b1 || payload_data !== 8'hEA) begin
            errors++; $display("FAIL bp_hold%0d: valid=%b data=%h required 1/ea", i, payload_valid, payload_data);
         end
         if (i < 3) begin @(posedge clk); #1; end
      end
      payload_ready = 1'b1;
      wait_idle("bp_idle");
      checks++;
      if (rx_q.size() - q0 !== 5 || n_done - d0 !== 1) begin
         errors++; $display("FAIL bp_count: bytes=%0d dones=%0d required 5/1", rx_q.size() - q0, n_done - d0);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[q0+i] !== PWM_PL[i]) begin
               errors++; $display("FAIL bp_byte%0d: got %h required %h", i, rx_q[q0+i], PWM_PL[i]);
            end
         end
      end
   endtask

   task automatic test_overrun();
      int d0 = n_done, e0 = n_err, q0 = rx_q.size(), n = 0;
      payload_ready = 1'b0;
      frm = '{8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h01, 8'hEA, 8'h60, 8'h75, 8'h30, 8'hF3};
      send_frm();
      while (!payload_valid && n < 20) begin @(posedge clk); #1; n++; end
      send_byte(8'h5A);
      idle_cycles(2);
      checks++;
      if (n_err - e0 !== 1 || last_err !== ERR_OVERRUN || payload_valid !== 1'b1 || payload_data !== 8'h01) begin
         errors++; $display("FAIL ovr_err: errs=%0d code=%b valid=%b data=%h required 1/00/1/01", n_err - e0, last_err, payload_valid, payload_data);
      end
      payload_ready = 1'b1;
      wait_idle("ovr_idle");
      checks++;
      if (rx_q.size() - q0 !== 5 || n_done - d0 !== 1 || n_err - e0 !== 1) begin
         errors++; $display("FAIL ovr_drain: bytes=%0d dones=%0d errs=%0d required 5/1/1", rx_q.size() - q0, n_done - d0, n_err - e0);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[q0+i] !== PWM_PL[i]) begin
               errors++; $display("FAIL ovr_byte%0d: got %h required %h", i, rx_q[q0+i], PWM_PL[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int d0 = n_done, e0 = n_err, n = 0;
      payload_ready = 1'b0;
      frm = '{8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h01, 8'hEA, 8'h60, 8'h75, 8'h30, 8'hF3};
      send_frm();
      while (!payload_valid && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (payload_valid !== 1'b1 || payload_data !== 8'h01) begin
         errors++; $display("FAIL rst_drain_pre: valid=%b data=%h required 1/01", payload_valid, payload_data);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (payload_valid !== 1'b0 || busy !== 1'b0 || cmd_length !== 16'd0) begin
         errors++; $display("FAIL rst_drain_post: valid=%b busy=%b len=%h required 0/0/0000", payload_valid, busy, cmd_length);
      end
      payload_ready = 1'b1;
      idle_cycles(5);
      checks++;
      if (n_done - d0 !== 0 || n_err - e0 !== 0) begin
         errors++; $display("FAIL rst_drain_quiet: dones=%0d errs=%0d required 0/0", n_done - d0, n_err - e0);
      end
   endtask

   initial begin
      test_reset();
      test_heartbeat();
      test_pwm();
      test_bad_checksum();
      test_length();
      test_resync();
      test_timeout();
      test_backpressure();
      test_overrun();
      test_reset_mid_drain();
      test_heartbeat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
